serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial N-bit subtractor computing D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse counterpart of the team's gate-level full-adder datapath. It trades area for latency in the arithmetic unit and hands results to downstream logic through a start/done handshake.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iStart  input  1  start request; sampled only in IDLE.
- iA  input  WIDTH  minuend; captured on the accepted start edge.
- iB  input  WIDTH  subtrahend; captured on the accepted start edge.
- iBin  input  1  borrow-in; captured on the accepted start edge.
- oBusy  output  1  high in RUN and DONE; new starts are ignored while it is high.
- oDone  output  1  one-cycle pulse; oD and oBout are valid from this cycle.
- oD  output  WIDTH  difference (A − B − Bin) mod 2^WIDTH.
- oBout  output  1  borrow-out: 1 iff A < B + Bin, with both sides treated as unsigned.

## Operation

- Clock and reset: one clock, iClk. Reset iRst_n is asynchronous and active-low.
- Reset state: IDLE. oBusy=0, oDone=0, oD=0, oBout=0. Internal shift registers, borrow flip-flop and bit counter are all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - iStart=1 at an edge loads iA, iB and iBin into the shift registers and borrow flip-flop, clears the counter, and moves to RUN.
  - iStart=0 stays in IDLE.
- RUN, on each edge:
  - a0 and b0 are the current LSBs of the A and B shift registers; br is the borrow flip-flop.
  - Difference bit: d = a0 ^ b0 ^ br.
  - Next borrow: br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the working difference register, and the A and B registers shift right by one.
  - The counter increments. When the edge processes bit WIDTH−1, the FSM moves to DONE.
- Entry to DONE: the working difference register is copied into oD and the final borrow into oBout on the same edge.
- DONE: oDone=1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- Output stability: oD and oBout change only on entry to DONE or on reset. They hold the last result through IDLE, RUN and later operations until the next completion. Partial results never appear on oD.
- iStart in RUN or DONE has no effect, and any pending start is not queued. iA, iB and iBin may change freely after the accepted start edge.
- Arithmetic: all values are unsigned modulo 2^WIDTH; signed interpretation belongs to the consumer. The counter is $clog2(WIDTH) bits wide and never wraps within an operation.

## Timing

- Start accepted at edge 0, so oBusy=1 after edge 0.
- Bits 0..WIDTH−1 are processed at edges 1..WIDTH.
- After edge WIDTH: state is DONE, oDone=1, and oD/oBout are valid.
- After edge WIDTH+1: state is IDLE, oBusy=0, oDone=0.
- Latency from start edge to oDone is WIDTH cycles. The minimum start-to-start interval is WIDTH+2 cycles.
- iStart held high continuously restarts at the first edge where the FSM is in IDLE, which is edge WIDTH+2.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge, and the operation is discarded.
- Reset deasserted: the first start can be accepted at the first rising edge after deassertion.

## Test plan

- WIDTH=8, A=100, B=37, Bin=0 → oDone at edge 8 with oD=63 and oBout=0. oBusy is low after edge 9.
- A=5, B=9, Bin=0 → oD=8'hFC, oBout=1.
- A=0, B=0, Bin=1 → oD=8'hFF, oBout=1.
- A=8'hFF, B=8'h00, Bin=0 → oD=8'hFF, oBout=0.
- Start 200−50. Pulse iStart with A=1, B=1 at edges 3 and 8 → only one oDone, at edge 8, with oD=150. oD stays 150 until the next completion.
- Start 7−3. Assert iRst_n=0 between edges 4 and 5 → oBusy, oDone, oD and oBout are 0 immediately. After release, start 9−4 → oD=5 exactly 8 edges after that start.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, LSB first, one full-subtractor cell
// and a borrow flip-flop, with a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBin,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oD,
  output logic             oBout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_shift;

  // Full-subtractor cell on the current LSBs.
  assign d_bit      = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          a_d     = iA;
          b_d     = iB;
          br_d    = iBin;
          diff_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d = diff_shift;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Result registers load only here, so partial sums never reach oD.
          d_d     = diff_shift;
          bout_d  = br_next;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  assign oBusy = (state_q != S_IDLE);
  assign oDone = (state_q == S_DONE);
  assign oD    = d_q;
  assign oBout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: an arithmetic/timeline reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_serial_sub;

  localparam int W = 8;

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iStart = 1'b0;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic         iBin = 1'b0;
  logic         oBusy, oDone, oBout;
  logic [W-1:0] oD;

  int n_vec = 0;
  int n_bad = 0;

  serial_sub #(.WIDTH(W)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iStart(iStart),
    .iA    (iA),
    .iB    (iB),
    .iBin  (iBin),
    .oBusy (oBusy),
    .oDone (oDone),
    .oD    (oD),
    .oBout (oBout)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age = edges since the accepted start (-1 when idle).
  // The result is plain modular arithmetic on the captured operands.
  int           m_age = -1;
  logic [W-1:0] m_res_d, m_d;
  logic         m_res_b, m_b;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_age = -1;
      m_d   = '0;
      m_b   = 1'b0;
    end else if (m_age < 0) begin
      if (iStart) begin
        m_age   = 0;
        m_res_d = W'(int'(iA) - int'(iB) - int'(iBin));
        m_res_b = (int'(iA) < int'(iB) + int'(iBin));
      end
    end else if (m_age == W) begin
      m_age = -1;
    end else begin
      m_age++;
      if (m_age == W) begin
        m_d = m_res_d;
        m_b = m_res_b;
      end
    end
  end

  always @(negedge iClk) begin
    check("busy", 32'(oBusy), 32'(m_age >= 0));
    check("done", 32'(oDone), 32'(m_age == W));
    check("d",    32'(oD),    32'(m_d));
    check("bout", 32'(oBout), 32'(m_b));
  end

  // Launch one operation and wait (bounded) for oDone; returns edges to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat);
    @(negedge iClk);
    iA = a; iB = b; iBin = bin; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iA = '0; iB = '0; iBin = 1'b0;
    lat = -1;
    for (int k = 1; k <= W + 6; k++) begin
      @(negedge iClk);
      if (oDone) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int dones;

  initial begin
    repeat (2) @(negedge iClk);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_d",    32'(oD),    32'd0);
    check("rst_bout", 32'(oBout), 32'd0);
    iRst_n = 1'b1;

    // 100 - 37
    run_op(8'd100, 8'd37, 1'b0, lat);
    check("lat_100_37", 32'(lat), 32'd8);
    check("d_100_37",   32'(oD),  32'd63);
    check("b_100_37",   32'(oBout), 32'd0);
    @(negedge iClk);
    check("idle_after", 32'(oBusy), 32'd0);

    run_op(8'd5, 8'd9, 1'b0, lat);
    check("d_5_9", 32'(oD), 32'hFC);
    check("b_5_9", 32'(oBout), 32'd1);

    run_op(8'd0, 8'd0, 1'b1, lat);
    check("d_0_0_1", 32'(oD), 32'hFF);
    check("b_0_0_1", 32'(oBout), 32'd1);

    run_op(8'hFF, 8'h00, 1'b0, lat);
    check("d_ff_0", 32'(oD), 32'hFF);
    check("b_ff_0", 32'(oBout), 32'd0);

    run_op(8'h80, 8'h7F, 1'b1, lat);
    check("d_80_7f_1", 32'(oD), 32'h00);
    check("b_80_7f_1", 32'(oBout), 32'd0);

    // 200 - 50 with ignored start pulses at edges 3 and 8
    @(negedge iClk);
    @(negedge iClk);
    iA = 8'd200; iB = 8'd50; iBin = 1'b0; iStart = 1'b1;
    @(negedge iClk);                 // after edge 0
    iStart = 1'b0; iA = 8'd1; iB = 8'd1;
    dones = 0;
    for (int e = 1; e <= W + 5; e++) begin
      iStart = (e == 3 || e == 8);
      @(negedge iClk);               // after edge e
      iStart = 1'b0;
      if (oDone) begin
        dones++;
        check("ign_done_edge", 32'(e), 32'd8);
      end
    end
    check("ign_done_cnt", 32'(dones), 32'd1);
    check("ign_d_hold",   32'(oD),    32'd150);

    // Held-high start: completions at edges W and 2W+2
    iA = 8'd10; iB = 8'd3; iStart = 1'b1;
    @(negedge iClk);                 // after edge 0
    dones = 0;
    for (int e = 1; e <= 2 * W + 2; e++) begin
      @(negedge iClk);
      if (oDone) begin
        dones++;
        check("hold_edge", 32'(e), (dones == 1) ? 32'(W) : 32'(2 * W + 2));
      end
    end
    iStart = 1'b0;
    check("hold_dones", 32'(dones), 32'd2);
    check("hold_d",     32'(oD),    32'd7);
    repeat (W + 2) @(negedge iClk);

    // 7 - 3 aborted by reset between edges 4 and 5
    iA = 8'd7; iB = 8'd3; iBin = 1'b0; iStart = 1'b1;
    @(negedge iClk);                 // after edge 0
    iStart = 1'b0;
    repeat (4) @(negedge iClk);      // after edge 4
    #1 iRst_n = 1'b0;
    #1;
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_done", 32'(oDone), 32'd0);
    check("abort_d",    32'(oD),    32'd0);
    check("abort_bout", 32'(oBout), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;

    run_op(8'd9, 8'd4, 1'b0, lat);
    check("lat_9_4", 32'(lat), 32'd8);
    check("d_9_4",   32'(oD),  32'd5);
    check("b_9_4",   32'(oBout), 32'd0);

    repeat (3) @(negedge iClk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
